// File: rtl/fifo_tx_pkg.sv
// Shared types and line levels for the FIFO drain-side serial transmitter.
// Constants only; no timing or flow-control behaviour of its own.
package fifo_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic TX_IDLE_LVL  = 1'b1;
    localparam logic TX_START_LVL = 1'b0;
    localparam logic TX_STOP_LVL  = 1'b1;
    localparam int   DATA_BITS    = 4;

endpackage

// File: rtl/fifo_tx_baud.sv
// Bit-period counter: tick on the last cycle of each period, pre_tick one cycle earlier.
// Free-running from 0 after clear, wraps at CLKS_PER_BIT-1; no backpressure.
module fifo_tx_baud #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);

    localparam int unsigned   CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick     = (cnt == TERM);
    assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/fifo_tx_serializer.sv
// Pops 4-bit FIFO words and sends each as start / 4 data LSB-first / optional even parity / stop.
// First start bit 3 cycles after non-empty seen in IDLE; one pop per frame, frames always finish.
module fifo_tx_serializer
    import fifo_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_re,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned   IW       = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    tx_state_t            state, next_state;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 par_q, par_d;
    logic                 tick, pre_tick, clear;
    logic                 tx_d, re_d, busy_d, done_d;

    // Restarting the bit period on every state change keeps each bit exactly CLKS_PER_BIT long.
    assign clear = (next_state != state);

    fifo_tx_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .tick    (tick),
        .pre_tick(pre_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (en && !fifo_empty) next_state = ST_POP;
            ST_POP:    next_state = ST_LOAD;
            ST_LOAD:   next_state = ST_START;
            ST_START:  if (tick) next_state = ST_DATA;
            ST_DATA:   if (tick && idx_q == LAST_IDX) next_state = PARITY_EN ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tick) next_state = ST_STOP;
            ST_STOP:   if (tick) next_state = (en && !fifo_empty) ? ST_POP : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        if (state == ST_LOAD) begin
            shift_d = fifo_data;
            par_d   = ^fifo_data;
        end
        if (state != ST_DATA) begin
            idx_d = '0;
        end else if (tick) begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IW'(1);
        end
    end

    // Outputs are decoded from the upcoming state so the registered copies line up with it.
    always_comb begin
        tx_d   = TX_IDLE_LVL;
        re_d   = 1'b0;
        busy_d = (next_state != ST_IDLE);
        done_d = (state == ST_STOP) && pre_tick;
        case (next_state)
            ST_POP:    re_d = 1'b1;
            ST_START:  tx_d = TX_START_LVL;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_q;
            ST_STOP:   tx_d = TX_STOP_LVL;
            default:   tx_d = TX_IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q    <= '0;
            idx_q      <= '0;
            par_q      <= 1'b0;
            fifo_re    <= 1'b0;
            tx         <= TX_IDLE_LVL;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            par_q      <= par_d;
            fifo_re    <= re_d;
            tx         <= tx_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: doc/fifo_tx_serializer.md
# fifo_tx_serializer

Drain-side companion to the team's 8x4 FIFO. It pops 4-bit words through the FIFO's read port (`re`/`empty`/`data_out`) and transmits each word as an asynchronous serial frame on a single line. Frame order is start bit, 4 data bits LSB-first, optional even parity, stop bit. It sits between the FIFO read side and the board-level serial output pin.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range ≥ 2.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit after the data bits.
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset (asserted when 0).
- `en`, input, 1: 1 permits starting new pops; 0 stops new pops, but a frame already in progress completes.
- `fifo_empty`, input, 1: FIFO empty flag.
- `fifo_data`, input, 4: FIFO registered read data, valid the cycle after `fifo_re` is sampled.
- `fifo_re`, output, 1: FIFO read enable; a registered one-cycle pulse.
- `tx`, output, 1: serial line; idles high.
- `busy`, output, 1: 1 whenever state ≠ IDLE.
- `frame_done`, output, 1: one-cycle pulse in the last cycle of the stop bit.

## Operation
- FSM states are IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- **IDLE**
  - `tx`=1.
  - If `en`=1 and `fifo_empty`=0, go to POP.
- **POP**
  - `fifo_re`=1 for exactly this cycle.
  - Go to LOAD unconditionally.
- **LOAD**
  - Capture `fifo_data` into the shift register.
  - Compute parity = XOR of the 4 bits.
  - Go to START.
- **START**
  - `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- **DATA**
  - `tx` = shift_reg[0] for CLKS_PER_BIT cycles.
  - At the end of each bit period, shift right and increment the index.
  - After index 3, go to PARITY if PARITY_EN=1, else go to STOP.
- **PARITY**
  - `tx` = parity (even: the total count of 1s across data plus parity bit is even).
  - Hold for CLKS_PER_BIT cycles.
- **STOP**
  - `tx`=1 for CLKS_PER_BIT cycles.
  - `frame_done`=1 in the final cycle.
  - If `en`=1 and `fifo_empty`=0 in that final cycle, go directly to POP (back-to-back frames, no idle bit); otherwise go to IDLE.
- **Baud counter**
  - Width is `$clog2(CLKS_PER_BIT)`.
  - Cleared on every state entry.
  - Terminal count is CLKS_PER_BIT−1 and wraps to 0.
- **Boundary rules**
  - `fifo_re` is never asserted while `fifo_empty`=1.
  - At most one pop per frame.
  - `en` falling mid-frame does not truncate the frame.
  - `fifo_empty` rising after POP is ignored; the popped word is still sent.
  - The data bits on `tx` are exactly the word popped, with no dropped or duplicated words.
- **Reset mid-frame**
  - All outputs go immediately to reset values and state returns to IDLE.
  - The partially sent word is lost. The FIFO is not re-read for it.

## Timing
- Reset values: `fifo_re`=0, `tx`=1, `busy`=0, `frame_done`=0, state=IDLE, counters and shift register = 0.
- All outputs are registered; none are combinational from inputs.
- Latency from `fifo_empty`=0 sampled in IDLE:
  - cycle +1: `fifo_re`=1
  - cycle +2: LOAD
  - cycle +3: first start-bit cycle with `tx`=0
- Frame length is (6 + PARITY_EN)·CLKS_PER_BIT cycles, START through STOP.
- Back-to-back frame period is frame length + 2 cycles (POP, LOAD), during which `tx`=1.
- `busy` rises the cycle `fifo_re` rises. It falls the cycle after `frame_done` when returning to IDLE.

## Structure
- Shared package `fifo_tx_pkg` holds:
  - the state enum `tx_state_t`
  - constants `TX_IDLE_LVL`=1, `TX_START_LVL`=0, `TX_STOP_LVL`=1, `DATA_BITS`=4
- One sub-module, `fifo_tx_baud`:
  - a parameterized bit-period counter with a `clear` input and a `tick` output at terminal count
  - instantiated once in `fifo_tx_serializer`
- Everything else (FSM, shift register, parity) lives in the top module.

## Test plan
- **Reset:** `rst`=0 mid-DATA with CLKS_PER_BIT=4 → `tx`=1, `busy`=0, `fifo_re`=0 immediately. After release, nothing is transmitted while `fifo_empty`=1.
- **Single word:** FIFO holds 4'hA, CLKS_PER_BIT=4, PARITY_EN=0 → one `fifo_re` pulse. `tx` sequence is 0,0,1,0,1,1, each bit 4 cycles. `frame_done` pulses once.
- **Back-to-back:** FIFO holds 1, 2, 3 → three pops and three frames in order 1, 2, 3, each separated by exactly 2 idle-high cycles. `fifo_re` count = 3.
- **Parity:** PARITY_EN=1, word 4'h7 → parity bit 1. Word 4'h3 → parity bit 0. Total frame is 28 cycles at CLKS_PER_BIT=4.
- **Enable gating:** `en` dropped during DATA of word 5 with 6 still queued → word 5 completes and word 6 is not popped. Raising `en` → word 6 is sent.
- **Empty protection:** `fifo_empty` toggled randomly across 200 cycles → `fifo_re` is never 1 while `fifo_empty`=1. The transmitted sequence equals the pushed sequence.
